// File: rtl/dist_pkg.sv
// Shared sizing defaults, derivation helpers and loader state encoding.
package dist_pkg;

    localparam int D_DEF          = 256;
    localparam int BW_DEF         = 1;
    localparam int IN_W_DEF       = 32;
    localparam int ADDR_SPACE_DEF = 16;

    // Stream beats needed to fill one SRAM row.
    function automatic int calc_beats(input int d, input int bw, input int in_w);
        return (d * bw) / in_w;
    endfunction

    // Beat counter width; a single-beat row still needs a 1-bit counter.
    function automatic int calc_bcnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        LAST_WR = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/dist_row_packer.sv
// Packs IN_W-bit beats MSB-first into one ROW_W-bit row. The row output
// already contains the beat being pushed this cycle, so the loader can
// register a complete row on the same edge that accepts its last beat.
module dist_row_packer
    import dist_pkg::*;
#(
    parameter int ROW_W  = 256,
    parameter int IN_W   = 32,
    parameter int BEATS  = 8,
    parameter int BCNT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [IN_W-1:0]   beat,
    output logic [ROW_W-1:0]  row,
    output logic              row_full
);

    localparam logic [BCNT_W-1:0] LAST = BCNT_W'(BEATS - 1);

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;

    // Drop the incoming beat into its slot and advance the wrapping counter.
    always_comb begin
        row_d = row_q;
        cnt_d = cnt_q;
        if (push) begin
            row_d[(BEATS - 1 - int'(cnt_q)) * IN_W +: IN_W] = beat;
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Packing register and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            row_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            row_q <= row_d;
        end
    end

    assign row      = row_d;
    assign row_full = push && (cnt_q == LAST);

endmodule

// File: rtl/dist_sram_loader.sv
// Write-side front end of the distance SRAM bank: job FSM, row counter and
// address generation around a beat packer, driving the single write port.
module dist_sram_loader
    import dist_pkg::*;
#(
    parameter int D          = D_DEF,
    parameter int BW         = BW_DEF,
    parameter int IN_W       = IN_W_DEF,
    parameter int ADDR_SPACE = ADDR_SPACE_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_SPACE-1:0] base_addr,
    input  logic [ADDR_SPACE:0]   num_rows,
    input  logic                  in_valid,
    input  logic [IN_W-1:0]       in_data,
    output logic                  in_ready,
    output logic                  wsb,
    output logic [ADDR_SPACE-1:0] waddr,
    output logic [D*BW-1:0]       wdata,
    output logic                  busy,
    output logic                  done
);

    localparam int ROW_W  = D * BW;
    localparam int BEATS  = calc_beats(D, BW, IN_W);
    localparam int BCNT_W = calc_bcnt_w(BEATS);

    state_e                state_q, state_d;
    logic [ADDR_SPACE-1:0] base_q, base_d;
    logic [ADDR_SPACE:0]   rows_q, rows_d;
    logic [ADDR_SPACE:0]   ridx_q, ridx_d;
    logic                  wsb_q, wsb_d;
    logic [ADDR_SPACE-1:0] waddr_q, waddr_d;
    logic [ROW_W-1:0]      wdata_q, wdata_d;

    logic                  push;
    logic [ROW_W-1:0]      row;
    logic                  row_full;

    assign push = in_valid && (state_q == FILL);

    dist_row_packer #(
        .ROW_W  (ROW_W),
        .IN_W   (IN_W),
        .BEATS  (BEATS),
        .BCNT_W (BCNT_W)
    ) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .beat     (in_data),
        .row      (row),
        .row_full (row_full)
    );

    // Next-state, job capture and write-port launch.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        rows_d  = rows_q;
        ridx_d  = ridx_q;
        wsb_d   = 1'b1;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    rows_d  = num_rows;
                    ridx_d  = '0;
                    state_d = (num_rows != '0) ? FILL : DONE;
                end
            end
            FILL: begin
                if (row_full) begin
                    wsb_d   = 1'b0;
                    // Address wraps modulo the SRAM address space.
                    waddr_d = base_q + ridx_q[ADDR_SPACE-1:0];
                    wdata_d = row;
                    ridx_d  = ridx_q + 1'b1;
                    if (ridx_d == rows_q) state_d = LAST_WR;
                end
            end
            LAST_WR: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, job registers and registered SRAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            rows_q  <= '0;
            ridx_q  <= '0;
            wsb_q   <= 1'b1;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rows_q  <= rows_d;
            ridx_q  <= ridx_d;
            wsb_q   <= wsb_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready = (state_q == FILL);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign wsb      = wsb_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;

endmodule

// File: tb/tb_dist_sram_loader.sv
// Directed bench for dist_sram_loader: table of jobs plus reset-mid-job.
module tb_dist_sram_loader;

    localparam int AW    = 16;
    localparam int IN_W  = 32;
    localparam int RW    = 256;
    localparam int BEATS = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [AW:0]     num_rows = '0;
    logic            in_valid = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic            in_ready, wsb, busy, done;
    logic [AW-1:0]   waddr;
    logic [RW-1:0]   wdata;

    dist_sram_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wsb(wsb), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   rows;
        bit            toggle;
        int            restart_at;
        logic [31:0]   seed;
        logic [AW-1:0] exp_addr0;
        int            exp_writes;
    } vec_t;

    // Write-port monitor and SRAM bank model.
    logic [AW-1:0] w_addr[$];
    logic [RW-1:0] w_data[$];
    int            w_cyc[$];
    int            acc_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    bit            ready_seen = 0;
    bit            prev_low = 0;
    logic [RW-1:0] mem [logic [AW-1:0]];

    always @(negedge clk) begin
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (in_ready) ready_seen = 1;
        if (!wsb) begin
            chk("wsb_single_cycle", RW'(prev_low), RW'(0));
            w_addr.push_back(waddr);
            w_data.push_back(wdata);
            w_cyc.push_back(cyc);
            mem[waddr] = wdata;
        end
        prev_low = !wsb;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        w_addr.delete(); w_data.delete(); w_cyc.delete(); acc_cyc.delete();
        done_cnt = 0; ready_seen = 0;
    endtask

    task automatic run_job(input vec_t v);
        int start_cyc, total, to, nw, last;
        bit got;
        logic [RW-1:0] exp_row;
        logic [AW-1:0] exp_a;
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; base_addr = v.base; num_rows = v.rows;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
        total = int'(v.rows) * BEATS;
        for (int j = 0; j < total; j++) begin
            in_valid = 1'b1;
            in_data = v.seed + 32'(j);
            if (j == v.restart_at) begin
                start = 1'b1; base_addr = 16'h0F00; num_rows = 17'd1;
            end
            to = 0;
            do begin
                @(negedge clk); got = in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                to++;
            end while (!got && to < 100);
            if (!got) begin
                chk("beat_accept_timeout", RW'(0), RW'(1));
                break;
            end
            if (v.toggle) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        to = 0;
        while (done_cnt == 0 && to < 50) begin
            @(posedge clk); to++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("done_seen", RW'(done_cnt > 0), RW'(1));
        chk("done_pulse_count", RW'(done_cnt), RW'(1));
        nw = w_addr.size();
        chk("write_count", RW'(nw), RW'(v.exp_writes));
        for (int r = 0; r < nw && r < v.exp_writes; r++) begin
            exp_a = v.exp_addr0 + AW'(r);
            for (int k = 0; k < BEATS; k++)
                exp_row[RW-1-k*IN_W -: IN_W] = v.seed + 32'(r * BEATS + k);
            chk($sformatf("waddr_row%0d", r), RW'(w_addr[r]), RW'(exp_a));
            chk($sformatf("wdata_row%0d", r), w_data[r], exp_row);
            chk($sformatf("readback_row%0d", r), mem[exp_a], exp_row);
            if (acc_cyc.size() > r * BEATS + BEATS - 1)
                chk($sformatf("write_latency_row%0d", r), RW'(w_cyc[r]),
                    RW'(acc_cyc[r * BEATS + BEATS - 1] + 1));
        end
        if (v.rows == 0) begin
            chk("done_cycle_empty", RW'(done_cyc), RW'(start_cyc));
            chk("in_ready_never", RW'(ready_seen), RW'(0));
        end else if (acc_cyc.size() > 0) begin
            last = acc_cyc[acc_cyc.size() - 1];
            chk("done_cycle", RW'(done_cyc), RW'(last + 2));
            chk("beats_accepted", RW'(acc_cyc.size()), RW'(total));
        end
    endtask

    vec_t vecs[5];
    vec_t rv;

    initial begin
        vecs[0] = '{16'h0010, 17'd2, 1'b0, -1, 32'h0000_0000, 16'h0010, 2};
        vecs[1] = '{16'h0010, 17'd2, 1'b1, -1, 32'h0000_0000, 16'h0010, 2};
        vecs[2] = '{16'h1234, 17'd0, 1'b0, -1, 32'h0000_0000, 16'h1234, 0};
        vecs[3] = '{16'hFFFF, 17'd2, 1'b0, -1, 32'hA500_0000, 16'hFFFF, 2};
        vecs[4] = '{16'h0040, 17'd2, 1'b0,  3, 32'h1000_0000, 16'h0040, 2};

        #12;
        chk("reset_wsb", RW'(wsb), RW'(1));
        chk("reset_in_ready", RW'(in_ready), RW'(0));
        chk("reset_busy", RW'(busy), RW'(0));
        chk("reset_done", RW'(done), RW'(0));
        chk("reset_waddr", RW'(waddr), RW'(0));
        chk("reset_wdata", wdata, RW'(0));
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_job(vecs[i]);

        // Reset in the middle of row 0 after five beats.
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 16'h0020; num_rows = 17'd1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            in_data = 32'h0000_0100 + 32'(j);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_reset_busy", RW'(busy), RW'(1));
        rst_n = 1'b0;
        #1;
        chk("midjob_reset_wsb", RW'(wsb), RW'(1));
        chk("midjob_reset_in_ready", RW'(in_ready), RW'(0));
        chk("midjob_reset_busy", RW'(busy), RW'(0));
        chk("midjob_reset_waddr", RW'(waddr), RW'(0));
        chk("midjob_reset_wdata", wdata, RW'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("midjob_reset_no_write", RW'(w_addr.size()), RW'(0));
        @(negedge clk); rst_n = 1'b1;
        rv = '{16'h0020, 17'd1, 1'b0, -1, 32'h0000_0200, 16'h0020, 1};
        run_job(rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
